// File: rtl/spi_mem_responder_if.sv
// Serial link signals between spi_controller (master) and spi_mem_responder (slave).
// cs is active low; everything is sampled on the shared system clock.
interface spi_mem_responder_if;
    logic cs;
    logic mosi;
    logic miso;
    logic ready;
    logic op_done;

    modport master (
        output cs,
        output mosi,
        input  miso,
        input  ready,
        input  op_done
    );

    modport slave (
        input  cs,
        input  mosi,
        output miso,
        output ready,
        output op_done
    );
endinterface

// File: rtl/spi_mem_responder.sv
// SPI responder with a DEPTH x 8 register memory. It decodes LSB-first frames
// {data, addr, wr} and either commits a write or shifts the stored byte back out.
module spi_mem_responder #(
    parameter int DEPTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    spi_mem_responder_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        READY,
        SHIFT
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ready_q, ready_d;
    logic        op_done_q, op_done_d;

    logic [7:0]  mem_q [DEPTH];
    logic        mem_we;
    logic        in_range;
    logic [7:0]  rd_byte;

    // Widened compare keeps the range check correct even when DEPTH is 256.
    assign in_range = ({1'b0, addr_q} < 9'(DEPTH));
    assign rd_byte  = in_range ? mem_q[addr_q[AW-1:0]] : 8'h00;

    assign bus.miso    = (state_q == SHIFT) && shreg_q[0];
    assign bus.ready   = ready_q;
    assign bus.op_done = op_done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        shreg_d   = shreg_q;
        ready_d   = 1'b0;
        op_done_d = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (!bus.cs) begin
                    state_d = CMD;
                end
            end

            CMD: begin
                if (bus.cs) begin
                    state_d = IDLE;
                end else begin
                    wr_d    = bus.mosi;
                    cnt_d   = 3'd0;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (bus.cs) begin
                    state_d = IDLE;
                end else begin
                    addr_d = {bus.mosi, addr_q[7:1]};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d = 3'd0;
                        if (wr_q) begin
                            state_d = DATA;
                        end else begin
                            ready_d = 1'b1;
                            state_d = READY;
                        end
                    end
                end
            end

            DATA: begin
                if (bus.cs) begin
                    state_d = IDLE;
                end else begin
                    data_d = {bus.mosi, data_q[7:1]};
                    cnt_d  = cnt_q + 3'd1;
                    // Out-of-range writes still acknowledge so the controller never stalls.
                    if (cnt_q == 3'd7) begin
                        cnt_d     = 3'd0;
                        mem_we    = in_range;
                        op_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            READY: begin
                shreg_d = rd_byte;
                cnt_d   = 3'd0;
                state_d = SHIFT;
            end

            SHIFT: begin
                shreg_d = {1'b0, shreg_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            wr_q      <= 1'b0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            shreg_q   <= 8'h00;
            ready_q   <= 1'b0;
            op_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            shreg_q   <= shreg_d;
            ready_q   <= ready_d;
            op_done_q <= op_done_d;
        end
    end

    // data_d already holds the final bit, so the commit lands on the last data edge.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[addr_q[AW-1:0]] <= data_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: each task drives whole frames and checks
// per-cycle logs of ready/op_done/miso against hand-computed vectors.
module tb_spi_mem_responder;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    spi_mem_responder_if bus();

    spi_mem_responder #(.DEPTH(32)) dut (
        .clk_i    (clk),
        .reset_ni (resetN),
        .bus      (bus)
    );

    int assertCount = 0;
    int failCount   = 0;

    logic [23:0] readyLog;
    logic [23:0] opLog;
    logic [23:0] misoLog;
    logic [7:0]  expMem [32];

    // Log index j is the cycle T+j, where T is the turnaround cycle.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                                 input int csLow, input int nCyc, input int resetAt);
        logic [16:0] bits;
        bits     = {data, addr, wr};
        readyLog = '0;
        opLog    = '0;
        misoLog  = '0;
        for (int j = 0; j < nCyc; j++) begin
            @(negedge clk);
            readyLog[j] = bus.ready;
            opLog[j]    = bus.op_done;
            misoLog[j]  = bus.miso;
            resetN      = (j == resetAt) ? 1'b0 : 1'b1;
            bus.cs      = (j < csLow) ? 1'b0 : 1'b1;
            if (j == 0)
                bus.mosi = 1'b1;
            else if (j - 1 < 17)
                bus.mosi = bits[j-1];
            else
                bus.mosi = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetN   = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        assertCount++;
        if (bus.miso !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_miso: got %b expected 0", bus.miso);
        end
        assertCount++;
        if (bus.ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready);
        end
        assertCount++;
        if (bus.op_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_op_done: got %b expected 0", bus.op_done);
        end
        resetN = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) expMem[i] = 8'h00;
    endtask

    task automatic test_write();
        applyStimulus(1'b1, 8'd3, 8'hA5, 18, 24, -1);
        expMem[3] = 8'hA5;
        assertCount++;
        if (opLog !== 24'h040000) begin
            failCount++;
            $display("[TB] FAIL write_op_done: got %h expected %h", opLog, 24'h040000);
        end
        assertCount++;
        if (readyLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL write_ready: got %h expected %h", readyLog, 24'h000000);
        end
        assertCount++;
        if (misoLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL write_miso: got %h expected %h", misoLog, 24'h000000);
        end
    endtask

    task automatic test_read();
        applyStimulus(1'b0, 8'd3, 8'h00, 10, 24, -1);
        assertCount++;
        if (readyLog !== 24'h000400) begin
            failCount++;
            $display("[TB] FAIL read_ready: got %h expected %h", readyLog, 24'h000400);
        end
        assertCount++;
        if (misoLog !== 24'h052800) begin
            failCount++;
            $display("[TB] FAIL read_miso: got %h expected %h", misoLog, 24'h052800);
        end
        assertCount++;
        if (opLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL read_op_done: got %h expected %h", opLog, 24'h000000);
        end
    endtask

    task automatic test_out_of_range();
        applyStimulus(1'b1, 8'd40, 8'h3C, 18, 24, -1);
        assertCount++;
        if (opLog !== 24'h040000) begin
            failCount++;
            $display("[TB] FAIL oor_write_op_done: got %h expected %h", opLog, 24'h040000);
        end
        applyStimulus(1'b0, 8'd40, 8'h00, 10, 24, -1);
        assertCount++;
        if (readyLog !== 24'h000400) begin
            failCount++;
            $display("[TB] FAIL oor_read_ready: got %h expected %h", readyLog, 24'h000400);
        end
        assertCount++;
        if (misoLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL oor_read_miso: got %h expected %h", misoLog, 24'h000000);
        end
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 8'(a), 8'h00, 10, 20, -1);
            assertCount++;
            if (misoLog !== ({16'h0000, expMem[a]} << 11)) begin
                failCount++;
                $display("[TB] FAIL oor_sweep_addr%0d: got %h expected %h", a, misoLog[18:11], expMem[a]);
            end
        end
    endtask

    task automatic test_abort();
        applyStimulus(1'b1, 8'd7, 8'hFF, 7, 24, -1);
        assertCount++;
        if (opLog !== 24'h000000 || readyLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL abort_pulses: got op %h ready %h expected 0", opLog, readyLog);
        end
        applyStimulus(1'b0, 8'd7, 8'h00, 10, 24, -1);
        assertCount++;
        if (misoLog !== 24'h000000 || readyLog !== 24'h000400) begin
            failCount++;
            $display("[TB] FAIL abort_read7: got miso %h ready %h expected 000000 000400", misoLog, readyLog);
        end
        applyStimulus(1'b1, 8'd7, 8'h5A, 18, 24, -1);
        expMem[7] = 8'h5A;
        assertCount++;
        if (opLog !== 24'h040000) begin
            failCount++;
            $display("[TB] FAIL abort_follow_write: got %h expected %h", opLog, 24'h040000);
        end
        applyStimulus(1'b0, 8'd7, 8'h00, 10, 24, -1);
        assertCount++;
        if (misoLog !== 24'h02D000) begin
            failCount++;
            $display("[TB] FAIL abort_follow_read: got %h expected %h", misoLog, 24'h02D000);
        end
    endtask

    task automatic test_reset_mid_shift();
        // Reset in T+13: bits 0..2 of 0xA5 appear, then miso goes quiet.
        applyStimulus(1'b0, 8'd3, 8'h00, 10, 24, 13);
        for (int i = 0; i < 32; i++) expMem[i] = 8'h00;
        assertCount++;
        if (misoLog !== 24'h002800) begin
            failCount++;
            $display("[TB] FAIL rst_shift_miso: got %h expected %h", misoLog, 24'h002800);
        end
        assertCount++;
        if (readyLog !== 24'h000400 || opLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL rst_shift_pulses: got ready %h op %h expected 000400 000000", readyLog, opLog);
        end
        applyStimulus(1'b0, 8'd3, 8'h00, 10, 24, -1);
        assertCount++;
        if (misoLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL rst_shift_read3: got %h expected %h", misoLog, 24'h000000);
        end
        applyStimulus(1'b0, 8'd7, 8'h00, 10, 24, -1);
        assertCount++;
        if (misoLog !== 24'h000000) begin
            failCount++;
            $display("[TB] FAIL rst_shift_read7: got %h expected %h", misoLog, 24'h000000);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 8'd31, 8'h01, 18, 19, -1);
        assertCount++;
        if (opLog !== 24'h040000) begin
            failCount++;
            $display("[TB] FAIL b2b_write31: got %h expected %h", opLog, 24'h040000);
        end
        applyStimulus(1'b1, 8'd0, 8'h80, 18, 19, -1);
        assertCount++;
        if (opLog !== 24'h040000) begin
            failCount++;
            $display("[TB] FAIL b2b_write0: got %h expected %h", opLog, 24'h040000);
        end
        applyStimulus(1'b0, 8'd31, 8'h00, 10, 20, -1);
        assertCount++;
        if (misoLog !== 24'h000800 || readyLog !== 24'h000400) begin
            failCount++;
            $display("[TB] FAIL b2b_read31: got miso %h ready %h expected 000800 000400", misoLog, readyLog);
        end
        applyStimulus(1'b0, 8'd0, 8'h00, 10, 20, -1);
        assertCount++;
        if (misoLog !== 24'h040000 || readyLog !== 24'h000400) begin
            failCount++;
            $display("[TB] FAIL b2b_read0: got miso %h ready %h expected 040000 000400", misoLog, readyLog);
        end
    endtask

    initial begin
        resetN   = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_abort();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI responder (target) side of the team's single-clock SPI link: a 32 x 8 register memory written and read by `spi_controller` frames. It deserialises LSB-first command frames on `mosi` while `cs` is low, commits writes and acknowledges them with `op_done`, and serves reads by asserting `ready` and then shifting the stored byte out on `miso`. The responder shares `clk` with the controller; every signal is sampled and driven on `posedge clk`, with no separate serial clock.

## Interface
- `DEPTH`, 32: number of memory bytes; valid addresses are 0..DEPTH-1.
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `cs`  input  1  chip select, active low, from controller.
- `mosi`  input  1  serial command/data from controller.
- `miso`  output  1  serial read data to controller.
- `ready`  output  1  one-cycle pulse: read data follows on `miso`.
- `op_done`  output  1  one-cycle pulse: write frame committed.

## Operation
- Frame format, LSB first: bit0 = `wr`; bits 1..8 = `addr[7:0]`; bits 9..16 = `data[7:0]`, write frames only. A read frame has 9 bits.
- States:
  - IDLE: wait for `cs`==0. The first cycle `cs` is sampled low is a turnaround cycle; `mosi` is ignored in it. Go to CMD.
  - CMD: sample `wr`. Go to ADDR.
  - ADDR: sample 8 address bits using a bit counter 0..7. After bit 7, go to DATA if `wr`=1, else READY.
  - DATA: sample 8 data bits. After bit 7, write `mem[addr]` if `addr` < DEPTH, pulse `op_done`, and go to IDLE.
  - READY: latch `mem[addr]`, or 0x00 if `addr` >= DEPTH, into the shift register. Pulse `ready`. Go to SHIFT.
  - SHIFT: drive the shift register LSB first for 8 cycles, then go to IDLE.
- `cs` rising in CMD/ADDR/DATA before the last bit is sampled aborts the frame: go to IDLE; no write, no `op_done`, no `ready`.
- In READY/SHIFT, `cs` is ignored. The controller raises `cs` after the address; the read completes regardless.
- Out-of-range write (`addr` >= DEPTH): memory is unchanged, but `op_done` still pulses so the controller does not hang.
- A new frame is recognised only from IDLE. Leaving DATA or SHIFT always passes through IDLE for at least one cycle.

## Timing
- Reset (`reset`==0 at a clock edge):
  - State goes to IDLE and counters are cleared.
  - `miso`=0, `ready`=0, `op_done`=0.
  - All memory bytes are cleared to 0x00.
  - Reset applied mid-frame or mid-shift discards the operation with no pulses.
- Let T be the cycle in which `cs` is first sampled low (turnaround). `wr` is sampled in T+1, `addr[i]` in T+2+i, and `data[i]` in T+10+i.
- Write: the memory update happens on the edge ending T+17. `op_done` is high in T+18 only.
- Read: `ready` is high in T+10 only. `miso` carries `data[k]` in T+11+k for k=0..7. `miso` is 0 in every other cycle.
- `ready` and `op_done` are registered, never asserted together, and never held longer than one cycle.
- `mosi` is only sampled while `cs`==0 in CMD/ADDR/DATA.
- Read-after-write: the byte is visible to a read frame whose T is at or after write T+18.

## Test plan
- Reset, then write 0xA5 to addr 3 → `op_done` high for exactly one cycle at T+18, `miso` and `ready` stay 0.
- Read addr 3 after that write → `ready` pulse at T+10, then `miso` = 1,0,1,0,0,1,0,1 over T+11..T+18, then 0.
- Write 0x3C to addr 40 → `op_done` pulses. A read of addr 40 returns 0x00, and reads of addr 0..31 are unchanged.
- Raise `cs` after 5 address bits of a write of 0xFF to addr 7 → no `op_done`. A read of addr 7 returns the prior value (0x00 after reset). A following full frame decodes correctly.
- Assert `reset` during SHIFT of a read of 0xA5 → `miso`=0 on the next cycle and no further bits. A subsequent read of addr 3 returns 0x00.
- Back-to-back: write 0x01 to addr 31, write 0x80 to addr 0, read 31, read 0 → read data 0x01 and 0x80. The last address (31) wraps nothing and stays addressable.
